// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode constants, instruction field helpers,
// stage-4 z5 mux encodings and the memory-stage FSM state encoding.
package pipe_pkg;

  localparam logic [5:0] OP_LOAD  = 6'h23;
  localparam logic [5:0] OP_STORE = 6'h2B;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;

  localparam logic [1:0] Z5_READ_DATA = 2'd0;
  localparam logic [1:0] Z5_Z4        = 2'd1;
  localparam logic [1:0] Z5_PC4       = 2'd2;

  localparam int TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] ir);
    return ir[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [4:0] rt_of(input logic [31:0] ir);
    return ir[RT_HI:RT_LO];
  endfunction

endpackage

// File: rtl/mem_fwd_detect.sv
// Store-data forwarding compare for stage 4.
// A store in stage 4 takes its write data from z5 (forwarded) when the
// instruction in stage 5 writes the same, non-zero register.
// Ports:
//   ir4_output        in  32  instruction in stage 4
//   ir5_output        in  32  instruction in stage 5
//   select_writedata  out 1   0 = forward z5_output, 1 = md4_output
module mem_fwd_detect
  import pipe_pkg::*;
(
  input  logic [31:0] ir4_output,
  input  logic [31:0] ir5_output,
  output logic        select_writedata
);

  logic ir4_is_store;
  logic ir5_writes_reg;
  logic rt_match;
  logic unused_ir4_bits;

  assign ir4_is_store   = (opcode_of(ir4_output) == OP_STORE);
  // An all-zero word is the NOP bubble; stores write memory, not a register.
  assign ir5_writes_reg = (opcode_of(ir5_output) != OP_STORE) && (ir5_output != 32'd0);
  // r0 is hardwired, so a match on it never needs forwarding.
  assign rt_match       = (rt_of(ir5_output) == rt_of(ir4_output)) && (rt_of(ir4_output) != 5'd0);

  assign select_writedata = !(ir4_is_store && ir5_writes_reg && rt_match);

  assign unused_ir4_bits = ^{ir4_output[25:21], ir4_output[15:0]};

endmodule

// File: rtl/mem_stage_ctrl.sv
// Stage-4 (memory stage) controller. Decodes ir4, drives the stage-4 mux
// selects and sequences the data-memory req/ack access, stalling stages 1-4
// and injecting a NOP bubble into ir5 while an access is pending.
// Optional feature: MEM_TIMEOUT_EN adds an ACCESS timeout with a sticky
// mem_err flag; without it ACCESS waits indefinitely and mem_err is 0.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   ir4_output        instruction in stage 4
//   ir5_output        instruction in stage 5 (store-data forwarding)
//   mem_ack           data memory access complete
//   mem_req, mem_we   registered memory request / write enable
//   select_z5         0=read_data 1=z4_output 2=pc4_output
//   select_writedata  0=z5_output (forwarded) 1=md4_output
//   select_ir5        0=pass ir4 1=nop bubble
//   stall             hold stage 1-4 registers
//   mem_err           sticky access-timeout flag
//   state_dbg         current FSM state
// Handshake: mem_req rises on ACCESS entry and stays high until the cycle
// after mem_ack is seen high in ACCESS; mem_ack outside ACCESS is ignored.
module mem_stage_ctrl
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir4_output,
  input  logic [31:0] ir5_output,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  select_z5,
  output logic        select_writedata,
  output logic        select_ir5,
  output logic        stall,
  output logic        mem_err,
  output mem_state_t  state_dbg
);

  mem_state_t state;
  logic [5:0] opc;
  logic       is_store;
  logic       is_mem;

  assign opc      = opcode_of(ir4_output);
  assign is_store = (opc == OP_STORE);
  assign is_mem   = (opc == OP_LOAD) || is_store;

  always_comb begin
    select_z5 = Z5_Z4;
    if (opc == OP_LOAD)     select_z5 = Z5_READ_DATA;
    else if (opc == OP_JAL) select_z5 = Z5_PC4;
  end

  mem_fwd_detect u_fwd (
    .ir4_output       (ir4_output),
    .ir5_output       (ir5_output),
    .select_writedata (select_writedata)
  );

`ifdef MEM_TIMEOUT_EN
  logic [4:0] count;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      mem_err <= 1'b0;
      count   <= 5'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_mem) begin
            state   <= ST_ACCESS;
            mem_req <= 1'b1;
            mem_we  <= is_store;
`ifdef MEM_TIMEOUT_EN
            count   <= 5'd0;
`endif
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            state   <= ST_DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
`ifdef MEM_TIMEOUT_EN
          else if (count == 5'(TIMEOUT_CYCLES - 1)) begin
            // Abort: the stage proceeds with undefined load data.
            state   <= ST_DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_err <= 1'b1;
          end else begin
            count <= count + 5'd1;
          end
`endif
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

`ifndef MEM_TIMEOUT_EN
  assign mem_err = 1'b0;
`endif

  // IDLE must stall in the same cycle a mem op appears in ir4, so stall and
  // select_ir5 are decoded from the registered state plus ir4. Reset forces
  // the quiescent values straight away.
  always_comb begin
    stall      = 1'b0;
    select_ir5 = 1'b1;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          stall      = is_mem;
          select_ir5 = is_mem;
        end
        ST_ACCESS: begin
          stall      = 1'b1;
          select_ir5 = 1'b1;
        end
        ST_DONE: begin
          stall      = 1'b0;
          select_ir5 = 1'b0;
        end
        default: begin
          stall      = 1'b0;
          select_ir5 = 1'b1;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule
